// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router crossbar: port indices and per-input state.
package noc_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } port_st_e;

endpackage

// File: rtl/noc_xbar_arb_if.sv
// Flit handshake bundle between input buffers, crossbar and link drivers.
interface noc_xbar_arb_if #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS-1:0]        in_tail;
    logic [NUM_PORTS*SEL_W-1:0]  in_dest;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_tail;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS-1:0]        err_dest;

    modport master (
        output in_data, in_valid, in_tail, in_dest, out_ready,
        input  in_ready, out_data, out_valid, out_tail, err_dest
    );

    modport slave (
        input  in_data, in_valid, in_tail, in_dest, out_ready,
        output in_ready, out_data, out_valid, out_tail, err_dest
    );
endinterface

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// advances past the winner only when a grant is issued.
module noc_rr_arb #(
    parameter int NUM_REQ = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    output logic [NUM_REQ-1:0] grant_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (grant_en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/noc_xbar_arb.sv
// NoC crossbar: per-output round-robin arbitration with wormhole locking and
// registered outputs (1-cycle latency); illegal heads are acked and dropped.
//   input state | meaning
//   ST_IDLE     | waiting for a head flit
//   ST_ACTIVE   | mid-packet, owns the output locked to it
//   ST_DROP     | mid-packet after an illegal head, acking flits until tail
module noc_xbar_arb
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input logic            clk,
    input logic            rst_n,
    noc_xbar_arb_if.slave  bus
);
    port_st_e             st_q [NUM_PORTS];
    port_st_e             st_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] lock_q, lock_d;
    logic [SEL_W-1:0]     own_q [NUM_PORTS];
    logic [SEL_W-1:0]     own_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] ov_q, ov_d, ot_q, ot_d, err_q, err_d;
    logic [DATA_W-1:0]    od_q [NUM_PORTS];
    logic [DATA_W-1:0]    od_d [NUM_PORTS];

    logic [SEL_W-1:0]     dest_v [NUM_PORTS];
    logic [NUM_PORTS-1:0] legal, head_req, can_acc, grant_en, fire, acc, drop_ack, mux_t;
    logic [NUM_PORTS-1:0] req [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
    logic [SEL_W-1:0]     src [NUM_PORTS];
    logic [DATA_W-1:0]    mux_d [NUM_PORTS];
    logic [NUM_PORTS*DATA_W-1:0] od_flat;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest_v[i]   = bus.in_dest[i*SEL_W +: SEL_W];
            legal[i]    = (dest_v[i] != SEL_W'(i)) && (int'(dest_v[i]) < NUM_PORTS);
            head_req[i] = bus.in_valid[i] && (st_q[i] == ST_IDLE);
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            can_acc[j]  = !ov_q[j] || bus.out_ready[j];
            grant_en[j] = !lock_q[j] && can_acc[j];
            for (int i = 0; i < NUM_PORTS; i++)
                req[j][i] = head_req[i] && legal[i] && (dest_v[i] == SEL_W'(j));
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
        noc_rr_arb #(.NUM_REQ(NUM_PORTS)) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (req[j]),
            .grant_en_i(grant_en[j]),
            .grant_o   (gnt[j])
        );
    end

    // An output fires either for a fresh grant or for the flit of its lock owner.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            fire[j]  = 1'b0;
            src[j]   = '0;
            mux_d[j] = '0;
            mux_t[j] = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[j][i] || (lock_q[j] && own_q[j] == SEL_W'(i) &&
                                  bus.in_valid[i] && can_acc[j])) begin
                    fire[j]  = 1'b1;
                    src[j]   = SEL_W'(i);
                    mux_d[j] = bus.in_data[i*DATA_W +: DATA_W];
                    mux_t[j] = bus.in_tail[i];
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            acc[i]      = 1'b0;
            drop_ack[i] = bus.in_valid[i] &&
                          ((st_q[i] == ST_DROP) || (st_q[i] == ST_IDLE && !legal[i]));
            for (int j = 0; j < NUM_PORTS; j++)
                if (fire[j] && src[j] == SEL_W'(i)) acc[i] = 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            lock_d[j] = lock_q[j];
            own_d[j]  = own_q[j];
            ov_d[j]   = ov_q[j];
            ot_d[j]   = ot_q[j];
            od_d[j]   = od_q[j];
            if (fire[j]) begin
                ov_d[j] = 1'b1;
                ot_d[j] = mux_t[j];
                od_d[j] = mux_d[j];
                if (!lock_q[j] && !mux_t[j]) begin
                    lock_d[j] = 1'b1;
                    own_d[j]  = src[j];
                end else if (lock_q[j] && mux_t[j]) begin
                    lock_d[j] = 1'b0;
                end
            end else if (bus.out_ready[j]) begin
                ov_d[j] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            st_d[i]  = st_q[i];
            err_d[i] = bus.in_valid[i] && (st_q[i] == ST_IDLE) && !legal[i];
            case (st_q[i])
                ST_IDLE:
                    if (bus.in_valid[i] && !bus.in_tail[i]) begin
                        if (!legal[i])   st_d[i] = ST_DROP;
                        else if (acc[i]) st_d[i] = ST_ACTIVE;
                    end
                ST_ACTIVE: if (acc[i] && bus.in_tail[i])            st_d[i] = ST_IDLE;
                ST_DROP:   if (bus.in_valid[i] && bus.in_tail[i])   st_d[i] = ST_IDLE;
                default:   st_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
            ov_q   <= '0;
            ot_q   <= '0;
            err_q  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                st_q[i]  <= ST_IDLE;
                own_q[i] <= '0;
                od_q[i]  <= '0;
            end
        end else begin
            lock_q <= lock_d;
            ov_q   <= ov_d;
            ot_q   <= ot_d;
            err_q  <= err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                st_q[i]  <= st_d[i];
                own_q[i] <= own_d[i];
                od_q[i]  <= od_d[i];
            end
        end
    end

    always_comb begin
        od_flat = '0;
        for (int j = 0; j < NUM_PORTS; j++) od_flat[j*DATA_W +: DATA_W] = od_q[j];
    end

    assign bus.in_ready  = acc | drop_ack;
    assign bus.out_data  = od_flat;
    assign bus.out_valid = ov_q;
    assign bus.out_tail  = ot_q;
    assign bus.err_dest  = err_q;
endmodule

// File: doc/noc_xbar_arb.md
Name: noc_xbar_arb

Overview:
Parametrised NoC router crossbar: NUM_PORTS inputs to NUM_PORTS outputs, DATA_W-bit flits, valid/ready handshake on every port. Each output has its own round-robin arbiter and wormhole lock held from a head flit until its tail flit. Outputs are registered, giving 1-cycle latency. Sits between the per-port input buffers and the link drivers; port index 0..4 = N,S,E,W,L when NUM_PORTS=5.

Parameters:
NUM_PORTS, 5, number of router ports (>=2)
DATA_W, 16, flit payload width
SEL_W, $clog2(NUM_PORTS), width of a destination port index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  NUM_PORTS*DATA_W  input flits, port i at [i*DATA_W +: DATA_W]
in_valid  in  NUM_PORTS  input flit valid
in_tail  in  NUM_PORTS  flit is last of packet (a head with tail=1 is a single-flit packet)
in_dest  in  NUM_PORTS*SEL_W  destination output index, sampled on head flits only
in_ready  out  NUM_PORTS  input flit accepted this cycle
out_data  out  NUM_PORTS*DATA_W  registered output flits
out_valid  out  NUM_PORTS  output flit valid
out_tail  out  NUM_PORTS  output flit is tail
out_ready  in  NUM_PORTS  downstream accepts output flit
err_dest  out  NUM_PORTS  1-cycle pulse: input i sent an illegal head (dest==i or dest>=NUM_PORTS)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: out_valid=0, out_tail=0, out_data=0, err_dest=0, all locks cleared, all RR pointers=0, all inputs idle. Reset mid-packet discards the packet; no partial flits are emitted afterwards.
- Per-input state IDLE/ACTIVE(out j). A head flit is in_valid on an IDLE input.
- Per-output state FREE/LOCKED(owner i).
- Output j can accept when out_valid[j]=0 or out_ready[j]=1.
- Arbitration (combinational): when output j is FREE and can accept, it grants one requester among IDLE inputs with a legal head targeting j. The winner is the first requester at or after rr_ptr[j], with wrap-around. On a grant, rr_ptr[j] <= winner+1 mod NUM_PORTS. The pointer does not move without a grant.
- Transfer: in_ready[i]=1 when (i is granted by j, or i is ACTIVE(j) with output j LOCKED(i)) and j can accept. On transfer:
  - out_data/out_tail[j] load next edge; out_valid[j]<=1.
  - Head with tail=0: j becomes LOCKED(i), i becomes ACTIVE(j).
  - Tail flit: j becomes FREE, i becomes IDLE.
  - Single-flit packet: no lock state change.
- Body/tail flits follow the lock; in_dest is ignored while ACTIVE.
- Output with out_valid=1 and out_ready=0 holds out_data/out_tail stable and back-pressures the owner (in_ready=0).
- Output freed by a tail in cycle t can grant a new head in cycle t+1, not t.
- Illegal head (U-turn dest==i, or dest>=NUM_PORTS): in_ready[i]=1 immediately, flit dropped. If tail=0, input enters DROP state and drops/acks flits until the tail. err_dest[i] pulses one cycle after the head.
- Latency in_valid&in_ready -> out_valid: 1 cycle. Full throughput: one flit per port per cycle with out_ready held high.
- Simultaneous events: every output arbitrates independently in the same cycle. An input requests at most one output, so no input is granted twice.

Decomposition:
- Shared package noc_pkg: PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4, and the port-state enum (IDLE/ACTIVE/DROP).
- One sub-module noc_rr_arb (NUM_REQ parameter; req vector, grant_en -> one-hot grant, internal pointer), instantiated per output.

Test Plan:
- Single-flit: L sends 16'hA5A5 dest=N(0), tail=1 -> cycle+1 out_valid[0]=1, out_data N=16'hA5A5, out_tail=1; other outputs out_valid=0.
- Contention: S,E,W each send single-flit heads to L(4) every cycle, pointer at 0 -> grants S,E,W,S,E,W... one flit per cycle on L.
- Wormhole: N sends 3-flit packet (0x0001, 0x0002, 0x0003 tail) to E while S sends a head to E at cycle 1 -> E outputs 1,2,3 contiguously, then S's flit; S in_ready=0 until the cycle after N's tail.
- Back-pressure: out_ready[E]=0 for 4 cycles mid-packet -> out_data E stable, in_ready of the owner 0; flits resume in order with no loss or duplication.
- Illegal: W head dest=W(3), 2 flits -> both acked, nothing on any output, err_dest[3] pulses once; same with dest=7.
- Async reset with rst_n low mid-packet -> outputs 0 immediately; after release a new head to the previously locked output is granted.
